operand_fetch_stage: RTL and testbench

Decode-to-execute pipeline stage that drives the read ports of the 2-read/1-write integer register file and consumes its read data. It resolves source operands with forwarding from EX and WB, stalls on RAW/WAW hazards against a 32-entry long-latency scoreboard, and presents one registered issue packet per cycle to execute over a valid/ready handshake. Per-instruction latency: one cycle from decode acceptance to issue valid.

---
 rtl/operand_fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch: RF read, EX/WB forwarding, long-op scoreboard, registered issue
module operand_fetch_stage #(
  parameter int DLEN = 32,
  parameter int ALEN = 5,
  parameter int PLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_dec_valid,
  output logic            o_dec_ready,
  input  logic [ALEN-1:0] i_dec_rs1,
  input  logic [ALEN-1:0] i_dec_rs2,
  input  logic [ALEN-1:0] i_dec_rd,
  input  logic            i_dec_use_rs1,
  input  logic            i_dec_use_rs2,
  input  logic            i_dec_rd_wen,
  input  logic            i_dec_long,
  input  logic [PLEN-1:0] i_dec_payload,
  output logic [ALEN-1:0] o_rf_raddr_a,
  output logic [ALEN-1:0] o_rf_raddr_b,
  input  logic [DLEN-1:0] i_rf_rdata_a,
  input  logic [DLEN-1:0] i_rf_rdata_b,
  input  logic            i_ex_fwd_valid,
  input  logic [ALEN-1:0] i_ex_fwd_addr,
  input  logic [DLEN-1:0] i_ex_fwd_data,
  input  logic            i_wb_wen,
  input  logic [ALEN-1:0] i_wb_waddr,
  input  logic [DLEN-1:0] i_wb_wdata,
  input  logic            i_wb_long_done,
  output logic            o_iss_valid,
  input  logic            i_iss_ready,
  output logic [DLEN-1:0] o_iss_rs1_data,
  output logic [DLEN-1:0] o_iss_rs2_data,
  output logic [ALEN-1:0] o_iss_rd,
  output logic            o_iss_rd_wen,
  output logic            o_iss_long,
  output logic [PLEN-1:0] o_iss_payload
);
  localparam int NREG = 1 << ALEN;

  logic            iss_valid_q, iss_valid_d;
  logic [DLEN-1:0] rs1_data_q, rs1_data_d;
  logic [DLEN-1:0] rs2_data_q, rs2_data_d;
  logic [ALEN-1:0] rd_q, rd_d;
  logic            rd_wen_q, rd_wen_d;
  logic            long_q, long_d;
  logic [PLEN-1:0] payload_q, payload_d;
  logic [NREG-1:0] sb_q, sb_d;

  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] sb_live;
  logic            haz_rs1, haz_rs2, haz_waw;
  logic            dec_ready, accept, iss_xfer;
  logic [DLEN-1:0] op_a, op_b;

  function automatic logic [DLEN-1:0] resolve(
    input logic [ALEN-1:0] addr,
    input logic [DLEN-1:0] rf_data,
    input logic            ex_v,
    input logic [ALEN-1:0] ex_a,
    input logic [DLEN-1:0] ex_d,
    input logic            wb_v,
    input logic [ALEN-1:0] wb_a,
    input logic [DLEN-1:0] wb_d
  );
    logic [DLEN-1:0] r;
    if (addr == '0)                  r = '0;
    else if (ex_v && ex_a == addr)   r = ex_d;
    else if (wb_v && wb_a == addr)   r = wb_d;
    else                             r = rf_data;
    return r;
  endfunction

  // A long op retiring on the WB port this cycle no longer blocks anyone.
  always_comb begin
    clr_vec = '0;
    if (i_wb_wen && i_wb_long_done) clr_vec = {{(NREG-1){1'b0}}, 1'b1} << i_wb_waddr;
    sb_live = sb_q & ~clr_vec;
  end

  always_comb begin
    haz_rs1 = i_dec_use_rs1 && (i_dec_rs1 != '0) &&
              (sb_live[i_dec_rs1] || (iss_valid_q && rd_wen_q && rd_q == i_dec_rs1));
    haz_rs2 = i_dec_use_rs2 && (i_dec_rs2 != '0) &&
              (sb_live[i_dec_rs2] || (iss_valid_q && rd_wen_q && rd_q == i_dec_rs2));
    haz_waw = i_dec_rd_wen && (i_dec_rd != '0) && sb_live[i_dec_rd];
    dec_ready = !(haz_rs1 || haz_rs2 || haz_waw) && !i_flush && (!iss_valid_q || i_iss_ready);
    accept    = i_dec_valid && dec_ready;
    iss_xfer  = iss_valid_q && i_iss_ready;
    op_a = resolve(i_dec_rs1, i_rf_rdata_a, i_ex_fwd_valid, i_ex_fwd_addr, i_ex_fwd_data,
                   i_wb_wen, i_wb_waddr, i_wb_wdata);
    op_b = resolve(i_dec_rs2, i_rf_rdata_b, i_ex_fwd_valid, i_ex_fwd_addr, i_ex_fwd_data,
                   i_wb_wen, i_wb_waddr, i_wb_wdata);
  end

  always_comb begin
    iss_valid_d = iss_valid_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    rd_d        = rd_q;
    rd_wen_d    = rd_wen_q;
    long_d      = long_q;
    payload_d   = payload_q;
    if (i_flush) begin
      iss_valid_d = 1'b0;
    end else if (accept) begin
      iss_valid_d = 1'b1;
      rs1_data_d  = op_a;
      rs2_data_d  = op_b;
      rd_d        = i_dec_rd;
      rd_wen_d    = i_dec_rd_wen;
      long_d      = i_dec_long;
      payload_d   = i_dec_payload;
    end else if (i_iss_ready) begin
      iss_valid_d = 1'b0;
    end
  end

  // Set is applied after clear so a new producer to the same register wins.
  always_comb begin
    sb_d = sb_live;
    if (iss_xfer && long_q && rd_wen_q && rd_q != '0) sb_d[rd_q] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      long_q      <= 1'b0;
      payload_q   <= '0;
      sb_q        <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rd_q        <= rd_d;
      rd_wen_q    <= rd_wen_d;
      long_q      <= long_d;
      payload_q   <= payload_d;
      sb_q        <= sb_d;
    end
  end

  assign o_dec_ready    = dec_ready;
  assign o_rf_raddr_a   = i_dec_rs1;
  assign o_rf_raddr_b   = i_dec_rs2;
  assign o_iss_valid    = iss_valid_q;
  assign o_iss_rs1_data = rs1_data_q;
  assign o_iss_rs2_data = rs2_data_q;
  assign o_iss_rd       = rd_q;
  assign o_iss_rd_wen   = rd_wen_q;
  assign o_iss_long     = long_q;
  assign o_iss_payload  = payload_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - directed and random checks of operand_fetch_stage against a behavioural model
module tb_operand_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, dec_valid, dec_use_rs1, dec_use_rs2, dec_rd_wen, dec_long;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_payload, rf_a, rf_b;
  logic        ex_valid, wb_wen, wb_long_done, iss_ready;
  logic [4:0]  ex_addr, wb_waddr;
  logic [31:0] ex_data, wb_wdata;

  logic        o_dec_ready, o_iss_valid, o_iss_rd_wen, o_iss_long;
  logic [4:0]  o_rf_raddr_a, o_rf_raddr_b, o_iss_rd;
  logic [31:0] o_iss_rs1_data, o_iss_rs2_data, o_iss_payload;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  operand_fetch_stage #(.DLEN(32), .ALEN(5), .PLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush),
    .i_dec_valid(dec_valid), .o_dec_ready(o_dec_ready),
    .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2), .i_dec_rd(dec_rd),
    .i_dec_use_rs1(dec_use_rs1), .i_dec_use_rs2(dec_use_rs2),
    .i_dec_rd_wen(dec_rd_wen), .i_dec_long(dec_long), .i_dec_payload(dec_payload),
    .o_rf_raddr_a(o_rf_raddr_a), .o_rf_raddr_b(o_rf_raddr_b),
    .i_rf_rdata_a(rf_a), .i_rf_rdata_b(rf_b),
    .i_ex_fwd_valid(ex_valid), .i_ex_fwd_addr(ex_addr), .i_ex_fwd_data(ex_data),
    .i_wb_wen(wb_wen), .i_wb_waddr(wb_waddr), .i_wb_wdata(wb_wdata),
    .i_wb_long_done(wb_long_done),
    .o_iss_valid(o_iss_valid), .i_iss_ready(iss_ready),
    .o_iss_rs1_data(o_iss_rs1_data), .o_iss_rs2_data(o_iss_rs2_data),
    .o_iss_rd(o_iss_rd), .o_iss_rd_wen(o_iss_rd_wen), .o_iss_long(o_iss_long),
    .o_iss_payload(o_iss_payload)
  );

  // Behavioural model: one-entry issue slot plus a set of registers with outstanding long writes.
  bit          m_valid, m_wen, m_long;
  logic [31:0] m_rs1, m_rs2, m_pay;
  logic [4:0]  m_rd;
  bit          m_sb [32];

  function automatic bit pending(input int r);
    return r != 0 && m_sb[r] && !(wb_wen && wb_long_done && int'(wb_waddr) == r);
  endfunction

  function automatic bit blocked(input bit use_s, input int r);
    return use_s && r != 0 && (pending(r) || (m_valid && m_wen && int'(m_rd) == r));
  endfunction

  function automatic bit exp_ready();
    return !blocked(dec_use_rs1, int'(dec_rs1)) && !blocked(dec_use_rs2, int'(dec_rs2)) &&
           !(dec_rd_wen && pending(int'(dec_rd))) && !flush && (!m_valid || iss_ready);
  endfunction

  function automatic logic [31:0] operand(input int r, input logic [31:0] rf);
    if (r == 0) return 32'h0;
    if (ex_valid && int'(ex_addr) == r) return ex_data;
    if (wb_wen && int'(wb_waddr) == r) return wb_wdata;
    return rf;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_wen <= 0; m_long <= 0;
      m_rs1 <= '0; m_rs2 <= '0; m_pay <= '0; m_rd <= '0;
      foreach (m_sb[i]) m_sb[i] <= 0;
    end else begin
      if (wb_wen && wb_long_done) m_sb[wb_waddr] <= 0;
      if (m_valid && iss_ready && m_long && m_wen && m_rd != 0) m_sb[m_rd] <= 1;
      if (flush) m_valid <= 0;
      else if (dec_valid && exp_ready()) begin
        m_valid <= 1;
        m_rs1 <= operand(int'(dec_rs1), rf_a);
        m_rs2 <= operand(int'(dec_rs2), rf_b);
        m_rd <= dec_rd; m_wen <= dec_rd_wen; m_long <= dec_long; m_pay <= dec_payload;
      end else if (iss_ready) m_valid <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("dec_ready", {31'b0, o_dec_ready}, {31'b0, exp_ready()});
      chk("raddr_a", {27'b0, o_rf_raddr_a}, {27'b0, dec_rs1});
      chk("raddr_b", {27'b0, o_rf_raddr_b}, {27'b0, dec_rs2});
      chk("iss_valid", {31'b0, o_iss_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk("iss_rs1", o_iss_rs1_data, m_rs1);
        chk("iss_rs2", o_iss_rs2_data, m_rs2);
        chk("iss_rd", {27'b0, o_iss_rd}, {27'b0, m_rd});
        chk("iss_rd_wen", {31'b0, o_iss_rd_wen}, {31'b0, m_wen});
        chk("iss_long", {31'b0, o_iss_long}, {31'b0, m_long});
        chk("iss_payload", o_iss_payload, m_pay);
      end
    end
  end

  task automatic idle();
    flush = 0; dec_valid = 0; dec_use_rs1 = 0; dec_use_rs2 = 0; dec_rd_wen = 0; dec_long = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_payload = 0; rf_a = 0; rf_b = 0;
    ex_valid = 0; ex_addr = 0; ex_data = 0; wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
    wb_long_done = 0; iss_ready = 1;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic dec(input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit wen, input bit lng, input logic [31:0] pay);
    dec_valid = 1; dec_rs1 = 5'(rs1); dec_use_rs1 = u1; dec_rs2 = 5'(rs2); dec_use_rs2 = u2;
    dec_rd = 5'(rd); dec_rd_wen = wen; dec_long = lng; dec_payload = pay;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk_on = 1;
    #2;
    chk("reset_valid", {31'b0, o_iss_valid}, 32'd0);
    chk("reset_payload", o_iss_payload, 32'd0);
    chk("reset_rs1", o_iss_rs1_data, 32'd0);
    chk("reset_ready", {31'b0, o_dec_ready}, 32'd1);

    // independent add r3 = f(r1, r2)
    next(); dec(1, 1, 2, 1, 3, 1, 0, 32'h1111_0003); rf_a = 5; rf_b = 7;
    #2 chk("add_ready", {31'b0, o_dec_ready}, 32'd1);
    next(); idle();
    #2 chk("add_valid", {31'b0, o_iss_valid}, 32'd1);
    chk("add_rs1", o_iss_rs1_data, 32'd5);
    chk("add_rs2", o_iss_rs2_data, 32'd7);

    // EX beats WB, WB beats stale RF
    next(); dec(1, 1, 0, 0, 0, 0, 0, 32'h2); rf_a = 32'h99;
    ex_valid = 1; ex_addr = 1; ex_data = 32'hAA; wb_wen = 1; wb_waddr = 1; wb_wdata = 32'h55;
    next(); ex_valid = 0;
    #2 chk("fwd_ex", o_iss_rs1_data, 32'hAA);
    next(); idle();
    #2 chk("fwd_wb", o_iss_rs1_data, 32'h55);

    // long load r4, consumer waits for WB long_done
    next(); dec(2, 1, 0, 0, 4, 1, 1, 32'h4);
    next(); dec(4, 1, 0, 0, 0, 0, 0, 32'h5); rf_a = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #2 chk("long_stall", {31'b0, o_dec_ready}, 32'd0);
      next();
    end
    wb_wen = 1; wb_waddr = 4; wb_wdata = 32'h1234; wb_long_done = 1;
    #2 chk("long_wake", {31'b0, o_dec_ready}, 32'd1);
    next(); wb_wen = 0; wb_long_done = 0;
    #2 chk("long_op", o_iss_rs1_data, 32'h1234);
    chk("sb4_clear", {31'b0, o_dec_ready}, 32'd1);

    // x0 reads ignore EX/WB traffic to x0; long op with rd=0
    next(); dec(0, 1, 0, 1, 0, 1, 1, 32'h6); rf_a = 32'h77; rf_b = 32'h88;
    ex_valid = 1; ex_addr = 0; ex_data = 32'hAAAA; wb_wen = 1; wb_waddr = 0; wb_wdata = 32'hBBBB;
    next(); idle();
    #2 chk("x0_rs1", o_iss_rs1_data, 32'd0);
    chk("x0_rs2", o_iss_rs2_data, 32'd0);
    next(); dec(0, 1, 0, 1, 0, 1, 0, 32'h7);
    #2 chk("x0_no_sb", {31'b0, o_dec_ready}, 32'd1);

    // back-pressure holds outputs; flush empties the slot
    next(); dec(9, 1, 10, 1, 11, 1, 0, 32'hCAFE); rf_a = 32'h100; rf_b = 32'h200;
    next(); dec(12, 1, 13, 1, 14, 1, 0, 32'hBEEF); iss_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("hold_valid", {31'b0, o_iss_valid}, 32'd1);
      chk("hold_rs1", o_iss_rs1_data, 32'h100);
      chk("hold_pay", o_iss_payload, 32'hCAFE);
      chk("hold_ready", {31'b0, o_dec_ready}, 32'd0);
      next();
    end
    flush = 1;
    next(); idle();
    #2 chk("flush_valid", {31'b0, o_iss_valid}, 32'd0);

    // r6 retire and new r6 producer issue on the same edge: set wins
    next(); dec(0, 0, 0, 0, 6, 1, 1, 32'h60);
    next(); dec(0, 0, 0, 0, 6, 1, 1, 32'h61);
    next(); idle(); wb_wen = 1; wb_waddr = 6; wb_long_done = 1; wb_wdata = 32'h66;
    next(); idle(); dec(6, 1, 0, 0, 0, 0, 0, 32'h62);
    #2 chk("sb6_set_wins", {31'b0, o_dec_ready}, 32'd0);
    next(); wb_wen = 1; wb_waddr = 6; wb_long_done = 1;
    #2 chk("sb6_clear", {31'b0, o_dec_ready}, 32'd1);

    // random traffic with occasional asynchronous reset
    for (int c = 0; c < 3000; c++) begin
      next();
      rst_n = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 19) == 0);
      dec_valid = ($urandom_range(0, 9) < 7);
      dec_rs1 = 5'($urandom_range(0, 7)); dec_rs2 = 5'($urandom_range(0, 7));
      dec_rd = 5'($urandom_range(0, 7));
      dec_use_rs1 = 1'($urandom); dec_use_rs2 = 1'($urandom); dec_rd_wen = 1'($urandom);
      dec_long = ($urandom_range(0, 9) < 3);
      dec_payload = $urandom; rf_a = $urandom; rf_b = $urandom;
      ex_valid = 1'($urandom); ex_addr = 5'($urandom_range(0, 7)); ex_data = $urandom;
      wb_wen = 1'($urandom); wb_waddr = 5'($urandom_range(0, 7)); wb_wdata = $urandom;
      wb_long_done = ($urandom_range(0, 9) < 3);
      iss_ready = ($urandom_range(0, 3) != 0);
    end
    next(); rst_n = 1; idle();
    @(negedge clk);
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
